// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
// Optional clear engine is built when FB_CLEAR_EN is defined.
package vga_fb_arbiter_pkg;

   // 640x480 @ 60 Hz timing, 25 MHz pixel clock
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Default framebuffer geometry
   localparam int FB_ADDR_W = 15;
   localparam int FB_DATA_W = 8;

   typedef logic [FB_ADDR_W-1:0] fb_addr_t;
   typedef logic [FB_DATA_W-1:0] pix_t;

   // Owner of the RAM port in the current cycle
   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_DISP,
      GNT_WR,
      GNT_CLR
   } grant_e;

   // Clear engine state, exported for observation
   typedef enum logic [1:0] {
      CLR_IDLE,
      CLR_SWEEP,
      CLR_DONE
   } clear_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Game-logic writer port of the framebuffer arbiter.
// Handshake: the writer raises wr_req with wr_addr/wr_data valid and holds
// all three stable until it sees wr_gnt=1; wr_gnt is combinational and the
// write commits on the clock edge where wr_req && wr_gnt. wr_gnt is never
// asserted without wr_req.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;

   modport master (output wr_req, output wr_addr, output wr_data, input wr_gnt);
   modport slave  (input wr_req, input wr_addr, input wr_data, output wr_gnt);
endinterface

// File: rtl/vga_fb_arbiter_fb_clear_engine.sv
// Clear engine: sweeps every framebuffer cell with a latched colour,
// advancing only in cycles where the arbiter leaves the RAM port free.
module vga_fb_arbiter_fb_clear_engine
   import vga_fb_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int FB_CELLS = 19200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] color,
   input  logic              slot_free,
   output logic              write_req,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done,
   output clear_state_e      state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_CELLS - 1);

   clear_state_e      state_n;
   logic [ADDR_W-1:0] cnt_q, cnt_n;
   logic [DATA_W-1:0] color_q, color_n;

   // State, sweep counter and latched colour registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= CLR_IDLE;
         cnt_q   <= '0;
         color_q <= '0;
      end else begin
         state   <= state_n;
         cnt_q   <= cnt_n;
         color_q <= color_n;
      end
   end

   // Next state and outputs; a start while not idle is dropped
   always_comb begin
      state_n   = state;
      cnt_n     = cnt_q;
      color_n   = color_q;
      write_req = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         CLR_IDLE: begin
            if (start) begin
               color_n = color;
               cnt_n   = '0;
               state_n = CLR_SWEEP;
            end
         end
         CLR_SWEEP: begin
            write_req = 1'b1;
            busy      = 1'b1;
            if (slot_free) begin
               if (cnt_q == LAST_ADDR) state_n = CLR_DONE;
               else                    cnt_n   = cnt_q + 1'b1;
            end
         end
         CLR_DONE: begin
            done    = 1'b1;
            state_n = CLR_IDLE;
         end
         default: state_n = CLR_IDLE;
      endcase
   end

   assign addr = cnt_q;
   assign data = color_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port arbiter: display fetch > writer > clear engine.
// Pixel byte and sync/blank leave two cycles after the timing inputs.
// Define FB_CLEAR_EN to build the clear engine; otherwise clear_start and
// clear_color are ignored and clear_busy/clear_done stay low.
module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
#(
   parameter int SCALE_SH = 2,
   parameter int FB_W     = H_VISIBLE >> SCALE_SH,
   parameter int FB_H     = V_VISIBLE >> SCALE_SH,
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8
) (
   input  logic              clk_25,
   input  logic              rst,
   input  logic [9:0]        hs,
   input  logic [9:0]        vs,
   input  logic              vga_blk,
   input  logic              vga_hsync,
   input  logic              vga_vsync,
   vga_fb_arbiter_if.slave   wr,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              hsync_d,
   output logic              vsync_d,
   output logic              blk_d,
   output clear_state_e      clear_state,
   output grant_e            grant
);

   localparam int FB_CELLS = FB_W * FB_H;

   logic              disp_slot;
   logic [ADDR_W-1:0] row, col, disp_addr;
   logic              clr_req;
   logic              clr_slot_free;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_data;
   logic              cap_q;
   logic [DATA_W-1:0] pix_q;
   logic              blk_p, hsync_p, vsync_p;

   // One fetch per cell column; the visible area never reaches the wrap point
   assign disp_slot = vga_blk && (hs[SCALE_SH-1:0] == '0);
   assign row       = ADDR_W'(vs >> SCALE_SH);
   assign col       = ADDR_W'(hs >> SCALE_SH);
   assign disp_addr = row * ADDR_W'(FB_W) + col;

   // The clear engine only advances when neither display nor writer wants the port
   assign clr_slot_free = rst && !disp_slot && !wr.wr_req;

`ifdef FB_CLEAR_EN
   vga_fb_arbiter_fb_clear_engine #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .FB_CELLS (FB_CELLS)
   ) u_clear (
      .clk       (clk_25),
      .rst       (rst),
      .start     (clear_start),
      .color     (clear_color),
      .slot_free (clr_slot_free),
      .write_req (clr_req),
      .addr      (clr_addr),
      .data      (clr_data),
      .busy      (clear_busy),
      .done      (clear_done),
      .state     (clear_state)
   );
`else
   logic              unused_clr_req;
   logic [ADDR_W-1:0] unused_clr_addr;
   logic [DATA_W-1:0] unused_clr_data;
   logic              unused_clr_busy;
   logic              unused_clr_done;
   clear_state_e      unused_clr_state;
   logic              unused_clear_in;

   // Engine kept permanently idle so its logic folds away to constants
   vga_fb_arbiter_fb_clear_engine #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .FB_CELLS (FB_CELLS)
   ) u_clear (
      .clk       (clk_25),
      .rst       (rst),
      .start     (1'b0),
      .color     ('0),
      .slot_free (clr_slot_free),
      .write_req (unused_clr_req),
      .addr      (unused_clr_addr),
      .data      (unused_clr_data),
      .busy      (unused_clr_busy),
      .done      (unused_clr_done),
      .state     (unused_clr_state)
   );

   assign unused_clear_in = ^{clear_start, clear_color};
   assign clr_req     = 1'b0;
   assign clr_addr    = '0;
   assign clr_data    = '0;
   assign clear_busy  = 1'b0;
   assign clear_done  = 1'b0;
   assign clear_state = CLR_IDLE;
`endif

   // Fixed-priority port mux; writes are suppressed entirely during reset
   always_comb begin
      grant     = GNT_NONE;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      wr.wr_gnt = 1'b0;
      if (rst) begin
         if (disp_slot) begin
            grant    = GNT_DISP;
            mem_addr = disp_addr;
         end else if (wr.wr_req) begin
            grant     = GNT_WR;
            wr.wr_gnt = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr.wr_addr;
            mem_wdata = wr.wr_data;
         end else if (clr_req) begin
            grant     = GNT_CLR;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = clr_data;
         end
      end
   end

   // Two-stage pixel pipeline: RAM read cycle, then capture; sync/blank follow
   always_ff @(posedge clk_25 or negedge rst) begin
      if (!rst) begin
         cap_q   <= 1'b0;
         pix_q   <= '0;
         blk_p   <= 1'b0;
         blk_d   <= 1'b0;
         hsync_p <= 1'b1;
         hsync_d <= 1'b1;
         vsync_p <= 1'b1;
         vsync_d <= 1'b1;
      end else begin
         cap_q   <= disp_slot;
         if (cap_q) pix_q <= mem_rdata;
         blk_p   <= vga_blk;
         blk_d   <= blk_p;
         hsync_p <= vga_hsync;
         hsync_d <= hsync_p;
         vsync_p <= vga_vsync;
         vsync_d <= vsync_p;
      end
   end

   assign pix_data = blk_d ? pix_q : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter (default build and FB_CLEAR_EN build).
module tb_vga_fb_arbiter;
   import vga_fb_arbiter_pkg::*;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;
   localparam int FB_W   = 160;
   localparam int FB_H   = 120;
   localparam int CELLS  = FB_W * FB_H;

   logic              clk_25 = 1'b0;
   logic              rst = 1'b0;
   logic [9:0]        hs = '0;
   logic [9:0]        vs = '0;
   logic              vga_blk = 1'b0;
   logic              vga_hsync = 1'b1;
   logic              vga_vsync = 1'b1;
   logic              clear_start = 1'b0;
   logic [DATA_W-1:0] clear_color = '0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              clear_busy, clear_done, mem_we, hsync_d, vsync_d, blk_d;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, pix_data;
   clear_state_e      clear_state;
   grant_e            grant;

   vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_bus ();

   vga_fb_arbiter #(
      .SCALE_SH (2),
      .FB_W     (FB_W),
      .FB_H     (FB_H),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) dut (
      .clk_25      (clk_25),
      .rst         (rst),
      .hs          (hs),
      .vs          (vs),
      .vga_blk     (vga_blk),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .wr          (wr_bus),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pix_data    (pix_data),
      .hsync_d     (hsync_d),
      .vsync_d     (vsync_d),
      .blk_d       (blk_d),
      .clear_state (clear_state),
      .grant       (grant)
   );

   // Clock: 40 ns period
   always #20 clk_25 = ~clk_25;

   // Watchdog
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] exp_q[$];

   typedef struct {
      logic [9:0]        hs;
      logic [9:0]        vs;
      logic              blk;
      logic              req;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic              chk_addr;
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_we;
      logic              exp_gnt;
      logic [DATA_W-1:0] exp_wdata;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic step();
      @(posedge clk_25);
      #2;
   endtask

   task automatic drive_bus(input logic [9:0] h, input logic [9:0] v, input logic b,
                            input logic req, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      hs = h;
      vs = v;
      vga_blk = b;
      wr_bus.wr_req  = req;
      wr_bus.wr_addr = a;
      wr_bus.wr_data = d;
   endtask

   initial begin
      int n_wr, bad, done_cnt, lost, wr_miss, clr_bad, clr_n, hp;
      logic done_seen;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] e;

      wr_bus.wr_req  = 1'b0;
      wr_bus.wr_addr = '0;
      wr_bus.wr_data = '0;

      vecs[0]  = '{10'd8,   10'd4,   1'b1, 1'b0, 15'h0000, 8'h00, 1'b1, 15'd162,   1'b0, 1'b0, 8'h00};
      vecs[1]  = '{10'd8,   10'd4,   1'b1, 1'b1, 15'h0100, 8'h33, 1'b1, 15'd162,   1'b0, 1'b0, 8'h00};
      vecs[2]  = '{10'd9,   10'd4,   1'b1, 1'b1, 15'h0100, 8'h33, 1'b1, 15'h0100,  1'b1, 1'b1, 8'h33};
      vecs[3]  = '{10'd0,   10'd0,   1'b1, 1'b1, 15'h0100, 8'h33, 1'b1, 15'd0,     1'b0, 1'b0, 8'h00};
      vecs[4]  = '{10'd1,   10'd0,   1'b1, 1'b1, 15'h0100, 8'h33, 1'b1, 15'h0100,  1'b1, 1'b1, 8'h33};
      vecs[5]  = '{10'd639, 10'd479, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 15'd0,     1'b0, 1'b0, 8'h00};
      vecs[6]  = '{10'd636, 10'd479, 1'b1, 1'b1, 15'h00AB, 8'h44, 1'b1, 15'd19199, 1'b0, 1'b0, 8'h00};
      vecs[7]  = '{10'd637, 10'd479, 1'b1, 1'b1, 15'h00AB, 8'h44, 1'b1, 15'h00AB,  1'b1, 1'b1, 8'h44};
      vecs[8]  = '{10'd4,   10'd0,   1'b0, 1'b1, 15'h7FFF, 8'hFF, 1'b1, 15'h7FFF,  1'b1, 1'b1, 8'hFF};
      vecs[9]  = '{10'd12,  10'd7,   1'b1, 1'b1, 15'h1234, 8'hA5, 1'b1, 15'd163,   1'b0, 1'b0, 8'h00};
      vecs[10] = '{10'd320, 10'd240, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b1, 15'd9680,  1'b0, 1'b0, 8'h00};
      vecs[11] = '{10'd640, 10'd480, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 15'd0,     1'b0, 1'b0, 8'h00};

      // Reset state: writer request must not leak through while rst=0
      step();
      drive_bus(10'd1, 10'd0, 1'b1, 1'b1, 15'h0005, 8'h09);
      step();
      #10;
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_wr_gnt", wr_bus.wr_gnt, 1'b0);
      check("rst_pix", pix_data, 8'h00);
      check("rst_hsync_d", hsync_d, 1'b1);
      check("rst_vsync_d", vsync_d, 1'b1);
      check("rst_blk_d", blk_d, 1'b0);
      check("rst_clear_busy", clear_busy, 1'b0);
      check("rst_clear_done", clear_done, 1'b0);
      check("rst_clear_state", 32'(clear_state), 32'(CLR_IDLE));
      step();
      drive_bus(10'd1, 10'd0, 1'b0, 1'b0, 15'h0000, 8'h00);
      rst = 1'b1;
      step();
      #10;
      check("post_rst_mem_we", mem_we, 1'b0);
      check("post_rst_wr_gnt", wr_bus.wr_gnt, 1'b0);
      check("post_rst_busy", clear_busy, 1'b0);
      check("post_rst_pix", pix_data, 8'h00);

      // Grant / address table
      for (int i = 0; i < 12; i++) begin
         step();
         drive_bus(vecs[i].hs, vecs[i].vs, vecs[i].blk, vecs[i].req, vecs[i].waddr, vecs[i].wdata);
         #10;
         if (vecs[i].chk_addr) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
         check($sformatf("vec%0d_gnt", i), wr_bus.wr_gnt, vecs[i].exp_gnt);
         if (vecs[i].exp_we) check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      end

      // Pixel pipeline: slots at hs=8,12,16; RAM data one cycle later; blanking from hs=18
      exp_q = {};
      for (int k = 0; k < 4; k++) exp_q.push_back(8'h5A);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'hC3);
      for (int k = 0; k < 2; k++) exp_q.push_back(8'h77);
      for (int k = 0; k < 2; k++) exp_q.push_back(8'h00);
      for (int h = 8; h <= 21; h++) begin
         step();
         drive_bus(10'(h), 10'd4, (h <= 17), 1'b0, 15'h0000, 8'h00);
         vga_hsync = h[0];
         vga_vsync = h[1];
         mem_rdata = (h == 9) ? 8'h5A : (h == 13) ? 8'hC3 : (h == 17) ? 8'h77 : 8'hEE;
         #10;
         if (h >= 10) begin
            hp = h - 2;
            e = exp_q.pop_front();
            check($sformatf("pix_h%0d", h), pix_data, e);
            check($sformatf("hsync_d_h%0d", h), hsync_d, hp[0]);
            check($sformatf("vsync_d_h%0d", h), vsync_d, hp[1]);
            check($sformatf("blk_d_h%0d", h), blk_d, (hp <= 17));
         end
      end
      check("pix_queue_drained", exp_q.size(), 0);
      vga_hsync = 1'b1;
      vga_vsync = 1'b1;
      mem_rdata = '0;

      // Writer waits exactly one cycle behind a display slot
      step();
      drive_bus(10'd0, 10'd0, 1'b1, 1'b1, 15'h0100, 8'h33);
      #10;
      check("wr_wait_gnt", wr_bus.wr_gnt, 1'b0);
      check("wr_wait_we", mem_we, 1'b0);
      step();
      hs = 10'd1;
      #10;
      check("wr_commit_gnt", wr_bus.wr_gnt, 1'b1);
      check("wr_commit_we", mem_we, 1'b1);
      check("wr_commit_addr", mem_addr, 15'h0100);
      check("wr_commit_data", mem_wdata, 8'h33);
      step();
      drive_bus(10'd2, 10'd0, 1'b1, 1'b0, 15'h0000, 8'h00);
      #10;
      check("wr_release_we", mem_we, 1'b0);

`ifdef FB_CLEAR_EN
      // Full sweep in vertical blanking, with an ignored restart mid-sweep
      step();
      drive_bus(10'd0, 10'd480, 1'b0, 1'b0, 15'h0000, 8'h00);
      clear_color = 8'h07;
      clear_start = 1'b1;
      #10;
      check("clr_start_busy", clear_busy, 1'b0);
      n_wr = 0; bad = 0; done_cnt = 0;
      for (int c = 0; c < CELLS + 100; c++) begin
         step();
         clear_start = (n_wr == 100);
         clear_color = clear_start ? 8'h99 : 8'h07;
         #10;
         if (mem_we === 1'b1) begin
            if (mem_addr !== 15'(n_wr) || mem_wdata !== 8'h07 || clear_busy !== 1'b1) bad++;
            n_wr++;
         end
         if (clear_done === 1'b1) begin
            done_cnt++;
            if (clear_busy !== 1'b0) bad++;
         end
      end
      check("clr_write_count", n_wr, CELLS);
      check("clr_bad_writes", bad, 0);
      check("clr_done_pulses", done_cnt, 1);
      check("clr_busy_after", clear_busy, 1'b0);
      check("clr_state_after", 32'(clear_state), 32'(CLR_IDLE));

      // Sweep during active video with a writer hogging every free slot
      hs = 10'd0; vs = 10'd0;
      lost = 0; wr_miss = 0; clr_bad = 0; clr_n = 0; done_seen = 1'b0;
      wr_bus.wr_addr = 15'h7FFF;
      wr_bus.wr_data = 8'hEE;
      for (int c = 0; c < 40000 && !done_seen; c++) begin
         step();
         if (c > 0) begin
            if (hs == 10'(H_TOTAL - 1)) begin
               hs = 10'd0;
               vs = (vs == 10'(V_TOTAL - 1)) ? 10'd0 : vs + 10'd1;
            end else begin
               hs = hs + 10'd1;
            end
         end
         vga_blk = (hs < 10'(H_VISIBLE)) && (vs < 10'(V_VISIBLE));
         wr_bus.wr_req = (c < 2000);
         clear_start = (c == 0);
         clear_color = 8'h3C;
         if (c == 2000) check("clr_stalled_by_writer", clr_n, 0);
         #10;
         ea = 15'(int'(vs >> 2) * FB_W + int'(hs >> 2));
         if (vga_blk && hs[1:0] == 2'b00) begin
            if (mem_we !== 1'b0 || mem_addr !== ea || wr_bus.wr_gnt !== 1'b0) lost++;
         end else if (wr_bus.wr_req) begin
            if (wr_bus.wr_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h7FFF) wr_miss++;
         end else if (clear_busy === 1'b1) begin
            if (mem_we === 1'b1 && mem_addr === 15'(clr_n) && mem_wdata === 8'h3C) clr_n++;
            else clr_bad++;
         end
         if (clear_done === 1'b1) done_seen = 1'b1;
      end
      check("mix_done_seen", done_seen, 1'b1);
      check("mix_display_lost", lost, 0);
      check("mix_writer_missed", wr_miss, 0);
      check("mix_clear_bad", clr_bad, 0);
      check("mix_clear_count", clr_n, CELLS);

      // Reset mid-sweep aborts without a done pulse; restart begins at 0
      step();
      drive_bus(10'd0, 10'd480, 1'b0, 1'b0, 15'h0000, 8'h00);
      clear_color = 8'h11;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      for (int c = 0; c < 300; c++) step();
      #10;
      check("abort_busy_before", clear_busy, 1'b1);
      step();
      rst = 1'b0;
      #1;
      check("abort_busy", clear_busy, 1'b0);
      check("abort_state", 32'(clear_state), 32'(CLR_IDLE));
      check("abort_we", mem_we, 1'b0);
      done_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         #10;
         if (clear_done !== 1'b0) done_cnt++;
      end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         #10;
         if (clear_done !== 1'b0 || clear_busy !== 1'b0) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      step();
      clear_color = 8'h22;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      #10;
      check("restart_addr0", mem_addr, 15'd0);
      check("restart_we0", mem_we, 1'b1);
      check("restart_data0", mem_wdata, 8'h22);
      step();
      #10;
      check("restart_addr1", mem_addr, 15'd1);
`else
      // Clear engine absent: start pulses have no effect
      step();
      drive_bus(10'd0, 10'd480, 1'b0, 1'b0, 15'h0000, 8'h00);
      clear_color = 8'h07;
      clear_start = 1'b1;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         clear_start = (c == 10);
         #10;
         if (clear_busy !== 1'b0 || clear_done !== 1'b0 || mem_we !== 1'b0) bad++;
      end
      check("noclr_idle", bad, 0);
      check("noclr_state", 32'(clear_state), 32'(CLR_IDLE));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
